// File: rtl/sift_kp_pkg.sv
// ----------------------------------------------------------------------------
// sift_kp_pkg
// Shared types and helpers for the SIFT keypoint collector.
//   kp_state_t : collector FSM states (IDLE, SKIP, RUN, DONE)
//   kp_word_t  : keypoint FIFO word {x, y, val[, pol]}
//   KP_WORD_W  : width of kp_word_t in bits
//   abs9()     : 9-bit magnitude of an 8-bit signed value (-128 -> 128)
// Optional feature macro: KP_POLARITY_EN adds the polarity bit to the word.
// ----------------------------------------------------------------------------
package sift_kp_pkg;

   localparam int KP_XW = 10;
   localparam int KP_YW = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SKIP = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } kp_state_t;

   typedef struct packed {
      logic [KP_XW-1:0] x;
      logic [KP_YW-1:0] y;
      logic [7:0]       val;
`ifdef KP_POLARITY_EN
      logic             pol;
`endif
   } kp_word_t;

   localparam int KP_WORD_W = $bits(kp_word_t);

   // Magnitude is one bit wider than the input so that -128 maps to 128.
   function automatic logic [8:0] abs9(input logic [7:0] v);
      logic [8:0] e;
      e = {v[7], v};
      return v[7] ? (9'd0 - e) : e;
   endfunction

endpackage

// File: rtl/sift_kp_fifo.sv
// ----------------------------------------------------------------------------
// sift_kp_fifo
// First-word-fall-through synchronous FIFO. The head entry is visible on
// rdata whenever empty=0. A push while full is accepted only when a pop
// happens in the same cycle; otherwise it is discarded.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   push, wdata    : write request and data
//   pop            : consume head (ignored while empty)
//   rdata          : head entry
//   full, empty    : occupancy flags
// Parameters: W (word width), DEPTH (power of 2, >= 2)
// ----------------------------------------------------------------------------
module sift_kp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_pop;
   logic          do_push;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sift_kp_collector.sv
// ----------------------------------------------------------------------------
// sift_kp_collector
// Rebuilds raster coordinates from the local-extreme flag stream (dropping the
// first LAG_PIX beats of window lag), rejects border and low-contrast
// candidates, and queues surviving keypoints in a FWFT FIFO.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   frame_start           : one-cycle pulse before the first beat of a frame
//   in_en/in_flag/in_val  : beat valid, extreme flag, signed centre DoG value
//   kp_valid/kp_ready     : FIFO head handshake
//   kp_x/kp_y/kp_val      : head keypoint (zero while kp_valid=0)
//   kp_pol                : head polarity, 1 = maximum (KP_POLARITY_EN only)
//   kp_count              : keypoints written this frame, saturating
//   overflow              : sticky, a qualified keypoint hit a full FIFO
//   frame_done            : one-cycle pulse after the last pixel of a frame
// Optional feature macro: KP_POLARITY_EN.
// ----------------------------------------------------------------------------
module sift_kp_collector
   import sift_kp_pkg::*;
#(
   parameter int IMG_W       = 640,
   parameter int IMG_H       = 480,
   parameter int XW          = KP_XW,
   parameter int YW          = KP_YW,
   parameter int LAG_PIX     = 641,
   parameter int BORDER      = 5,
   parameter int CONTRAST_TH = 3,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   input  logic          in_en,
   input  logic          in_flag,
   input  logic [7:0]    in_val,
   output logic          kp_valid,
   input  logic          kp_ready,
   output logic [XW-1:0] kp_x,
   output logic [YW-1:0] kp_y,
   output logic [7:0]    kp_val,
`ifdef KP_POLARITY_EN
   output logic          kp_pol,
`endif
   output logic [15:0]   kp_count,
   output logic          overflow,
   output logic          frame_done
);

   localparam int SW = $clog2(LAG_PIX + 1);

   kp_state_t             state;
   logic [SW-1:0]         skip_cnt;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic                  s1_valid;
   kp_word_t              s1_word;
   logic                  s2_valid;
   kp_word_t              s2_word;
   kp_word_t              beat_word;
   kp_word_t              head;
   logic [KP_WORD_W-1:0]  fifo_rdata;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
   logic                  push_ok;
   logic [8:0]            mag;
   logic                  qual;

   assign mag  = abs9(in_val);
   assign qual = in_flag
              && (x >= XW'(BORDER)) && (x <= XW'(IMG_W - 1 - BORDER))
              && (y >= YW'(BORDER)) && (y <= YW'(IMG_H - 1 - BORDER))
              && (mag >= 9'(CONTRAST_TH));

   always_comb begin
      beat_word     = '0;
      beat_word.x   = KP_XW'(x);
      beat_word.y   = KP_YW'(y);
      beat_word.val = in_val;
`ifdef KP_POLARITY_EN
      beat_word.pol = !in_val[7];
`endif
   end

   assign kp_valid = !fifo_empty;
   assign pop      = kp_valid && kp_ready;
   // A push into a full FIFO only lands if the head leaves in the same cycle.
   assign push_ok  = !fifo_full || pop;
   assign head     = kp_word_t'(fifo_rdata);
   assign kp_x     = kp_valid ? XW'(head.x) : '0;
   assign kp_y     = kp_valid ? YW'(head.y) : '0;
   assign kp_val   = kp_valid ? head.val    : '0;
`ifdef KP_POLARITY_EN
   assign kp_pol   = kp_valid && head.pol;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         skip_cnt   <= '0;
         x          <= '0;
         y          <= '0;
         s1_valid   <= 1'b0;
         s1_word    <= '0;
         s2_valid   <= 1'b0;
         s2_word    <= '0;
         kp_count   <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         s1_valid   <= 1'b0;
         s1_word    <= beat_word;
         s2_valid   <= s1_valid;
         s2_word    <= s1_word;

         if (s2_valid) begin
            if (push_ok) begin
               if (kp_count != 16'hFFFF) begin
                  kp_count <= kp_count + 16'd1;
               end
            end else begin
               overflow <= 1'b1;
            end
         end

         // frame_start wins over everything, including a push in flight
         // updating kp_count; a coincident beat is skip beat 0.
         if (frame_start) begin
            state    <= SKIP;
            skip_cnt <= '0;
            x        <= '0;
            y        <= '0;
            kp_count <= '0;
            overflow <= 1'b0;
            if (in_en) begin
               if (LAG_PIX == 1) begin
                  state <= RUN;
               end else begin
                  skip_cnt <= SW'(1);
               end
            end
         end else begin
            case (state)
               SKIP: begin
                  if (in_en) begin
                     if (skip_cnt == SW'(LAG_PIX - 1)) begin
                        state <= RUN;
                     end else begin
                        skip_cnt <= skip_cnt + 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (in_en) begin
                     s1_valid <= qual;
                     if (x == XW'(IMG_W - 1)) begin
                        x <= '0;
                        if (y == YW'(IMG_H - 1)) begin
                           state      <= DONE;
                           frame_done <= 1'b1;
                        end else begin
                           y <= y + 1'b1;
                        end
                     end else begin
                        x <= x + 1'b1;
                     end
                  end
               end
               IDLE, DONE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

   sift_kp_fifo #(
      .W     (KP_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s2_valid),
      .wdata (s2_word),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_sift_kp_collector.sv
// ----------------------------------------------------------------------------
// tb_sift_kp_collector
// Directed bench for sift_kp_collector on an 8x6 image, LAG_PIX=9, BORDER=1,
// CONTRAST_TH=3, FIFO_DEPTH=4. Beat n of a frame maps to pixel
// ((n-9) mod 8, (n-9) div 8); interior is x in 1..6, y in 1..4.
// ----------------------------------------------------------------------------
module tb_sift_kp_collector;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              frame_start = 1'b0;
   logic              in_en = 1'b0;
   logic              in_flag = 1'b0;
   logic signed [7:0] in_val = '0;
   logic              kp_ready = 1'b1;
   logic              kp_valid;
   logic [9:0]        kp_x;
   logic [8:0]        kp_y;
   logic signed [7:0] kp_val;
   logic [15:0]       kp_count;
   logic              overflow;
   logic              frame_done;
`ifdef KP_POLARITY_EN
   logic              kp_pol;
`endif

   int checks = 0;
   int failures = 0;
   int done_pulses = 0;

   logic              fl [64];
   logic signed [7:0] vl [64];

   typedef struct {
      int                beat;
      logic signed [7:0] val;
      logic              flag;
      logic              exp_q;
      int                exp_x;
      int                exp_y;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   sift_kp_collector #(
      .IMG_W       (8),
      .IMG_H       (6),
      .XW          (10),
      .YW          (9),
      .LAG_PIX     (9),
      .BORDER      (1),
      .CONTRAST_TH (3),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .in_en       (in_en),
      .in_flag     (in_flag),
      .in_val      (in_val),
      .kp_valid    (kp_valid),
      .kp_ready    (kp_ready),
      .kp_x        (kp_x),
      .kp_y        (kp_y),
      .kp_val      (kp_val),
`ifdef KP_POLARITY_EN
      .kp_pol      (kp_pol),
`endif
      .kp_count    (kp_count),
      .overflow    (overflow),
      .frame_done  (frame_done)
   );

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (frame_done) done_pulses++;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic clear_marks();
      for (int i = 0; i < 64; i++) begin
         fl[i] = 1'b0;
         vl[i] = '0;
      end
   endtask

   task automatic send_beat(input int i);
      in_en   = 1'b1;
      in_flag = fl[i];
      in_val  = vl[i];
      tick();
      in_en   = 1'b0;
      in_flag = 1'b0;
      in_val  = '0;
   endtask

   task automatic run_beats(input int last);
      for (int i = 0; i <= last; i++) send_beat(i);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_kp_valid", kp_valid, 0);
      chk("rst_kp_x", kp_x, 0);
      chk("rst_kp_count", kp_count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_frame_done", frame_done, 0);
      rst = 1'b1;
      tick();

      // ---------------- table-driven single-keypoint vectors ----------------
      vecs[0]  = '{28, 8'sd10,   1'b1, 1'b1, 3, 2};  // (3,2) interior
      vecs[1]  = '{9,  8'sd50,   1'b1, 1'b0, 0, 0};  // (0,0) corner
      vecs[2]  = '{16, 8'sd50,   1'b1, 1'b0, 0, 0};  // (7,0)
      vecs[3]  = '{17, 8'sd50,   1'b1, 1'b0, 0, 0};  // (0,1) left border
      vecs[4]  = '{18, 8'sd50,   1'b1, 1'b1, 1, 1};  // (1,1) first interior
      vecs[5]  = '{28, -8'sd2,   1'b1, 1'b0, 0, 0};  // low contrast
      vecs[6]  = '{28, 8'sd2,    1'b1, 1'b0, 0, 0};  // low contrast
      vecs[7]  = '{28, 8'sd3,    1'b1, 1'b1, 3, 2};  // exactly threshold
      vecs[8]  = '{28, -8'sd128, 1'b1, 1'b1, 3, 2};  // |-128| = 128
      vecs[9]  = '{28, 8'sd50,   1'b0, 1'b0, 0, 0};  // no flag
      vecs[10] = '{52, 8'sd50,   1'b1, 1'b0, 0, 0};  // (3,5) bottom border
      vecs[11] = '{47, 8'sd50,   1'b1, 1'b1, 6, 4};  // (6,4) last interior
      vecs[12] = '{8,  8'sd50,   1'b1, 1'b0, 0, 0};  // last skip beat

      for (int i = 0; i < NV; i++) begin
         start_frame();
         chk($sformatf("v%0d_count_clr", i), kp_count, 0);
         clear_marks();
         fl[vecs[i].beat] = vecs[i].flag;
         vl[vecs[i].beat] = vecs[i].val;
         run_beats(vecs[i].beat);
         tick();
         chk($sformatf("v%0d_valid_t1", i), kp_valid, 0);
         tick();
         chk($sformatf("v%0d_valid_t2", i), kp_valid, vecs[i].exp_q);
         if (vecs[i].exp_q) begin
            chk($sformatf("v%0d_x", i), kp_x, vecs[i].exp_x);
            chk($sformatf("v%0d_y", i), kp_y, vecs[i].exp_y);
            chk($sformatf("v%0d_val", i), kp_val, vecs[i].val);
            chk($sformatf("v%0d_count", i), kp_count, 1);
         end else begin
            chk($sformatf("v%0d_count", i), kp_count, 0);
         end
      end
      tick();

      // ---------------- contrast ordering ----------------
      kp_ready = 1'b0;
      start_frame();
      clear_marks();
      fl[19] = 1'b1; vl[19] = -8'sd2;
      fl[20] = 1'b1; vl[20] = 8'sd2;
      fl[21] = 1'b1; vl[21] = 8'sd3;
      fl[22] = 1'b1; vl[22] = -8'sd128;
      run_beats(22);
      repeat (3) tick();
      chk("ord_count", kp_count, 2);
      chk("ord_valid", kp_valid, 1);
      chk("ord_val0", kp_val, 3);
      chk("ord_x0", kp_x, 4);
      chk("ord_y0", kp_y, 1);
      kp_ready = 1'b1;
      tick();
      chk("ord_val1", kp_val, -128);
      chk("ord_x1", kp_x, 5);
      tick();
      chk("ord_empty", kp_valid, 0);
      chk("ord_overflow", overflow, 0);

      // ---------------- overflow, hold, frame_start keeps FIFO ----------------
      kp_ready = 1'b0;
      start_frame();
      clear_marks();
      for (int i = 0; i < 5; i++) begin
         fl[19+i] = 1'b1;
         vl[19+i] = 8'(10 + i);
      end
      run_beats(23);
      repeat (3) tick();
      chk("ovf_count", kp_count, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_valid", kp_valid, 1);
      chk("ovf_head", kp_val, 10);
      chk("ovf_head_x", kp_x, 2);
      tick();
      chk("ovf_hold", kp_val, 10);
      start_frame();
      chk("fs_count_clr", kp_count, 0);
      chk("fs_ovf_clr", overflow, 0);
      chk("fs_fifo_kept", kp_valid, 1);
      kp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d_valid", k), kp_valid, 1);
         chk($sformatf("drain%0d_val", k), kp_val, 10 + k);
         tick();
      end
      chk("drain_empty", kp_valid, 0);

      // ---------------- frame_done ----------------
      done_pulses = 0;
      start_frame();
      clear_marks();
      for (int i = 57; i < 62; i++) begin
         fl[i] = 1'b1;
         vl[i] = 8'sd50;
      end
      run_beats(55);
      chk("fd_before_last", frame_done, 0);
      send_beat(56);
      chk("fd_pulse", frame_done, 1);
      for (int i = 57; i < 62; i++) send_beat(i);
      repeat (3) tick();
      chk("fd_pulse_count", done_pulses, 1);
      chk("fd_extra_valid", kp_valid, 0);
      chk("fd_extra_count", kp_count, 0);

      // ---------------- asynchronous reset mid-RUN ----------------
      kp_ready = 1'b0;
      start_frame();
      clear_marks();
      fl[19] = 1'b1; vl[19] = 8'sd20;
      fl[20] = 1'b1; vl[20] = 8'sd21;
      run_beats(30);
      chk("pre_rst_count", kp_count, 2);
      chk("pre_rst_valid", kp_valid, 1);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_valid", kp_valid, 0);
      chk("arst_x", kp_x, 0);
      chk("arst_y", kp_y, 0);
      chk("arst_val", kp_val, 0);
      chk("arst_count", kp_count, 0);
      chk("arst_overflow", overflow, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      kp_ready = 1'b1;
      clear_marks();
      for (int i = 0; i < 41; i++) begin
         fl[i] = 1'b1;
         vl[i] = 8'sd50;
      end
      run_beats(40);
      repeat (3) tick();
      chk("idle_valid", kp_valid, 0);
      chk("idle_count", kp_count, 0);
      chk("idle_done", done_pulses, 1);
      start_frame();
      clear_marks();
      fl[28] = 1'b1; vl[28] = 8'sd7;
      run_beats(28);
      repeat (2) tick();
      chk("post_rst_valid", kp_valid, 1);
      chk("post_rst_val", kp_val, 7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sift_kp_collector.md
Name: sift_kp_collector

Overview:
Consumer-side partner of the SIFT local-extreme stage. It takes the per-pixel extreme flag stream and the centre DoG value, and reconstructs raster coordinates by compensating for the window lag. It drops border and low-contrast candidates, then queues surviving keypoints (x, y, value) in a FIFO with a valid/ready read port for the descriptor stage.

Parameters:
IMG_W, 640, pixels per line
IMG_H, 480, lines per frame
XW, 10, x coordinate width
YW, 9, y coordinate width
LAG_PIX, 641, input beats per frame discarded before the beat that maps to pixel (0,0)
BORDER, 5, pixels excluded on each image edge
CONTRAST_TH, 3, minimum |value| accepted (unsigned, 8 bits)
FIFO_DEPTH, 16, keypoint FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
frame_start  in  1  one-cycle pulse before the first beat of a frame
in_en  in  1  input beat valid (one pixel position per beat)
in_flag  in  1  extreme flag for this beat
in_val  in  8  signed centre DoG value for this beat
kp_valid  out  1  FIFO head valid
kp_ready  in  1  downstream accepts head
kp_x  out  XW  head x coordinate
kp_y  out  YW  head y coordinate
kp_val  out  8  head signed value
kp_count  out  16  keypoints written this frame, saturating at 16'hFFFF
overflow  out  1  sticky; a qualified keypoint was dropped because the FIFO was full
frame_done  out  1  one-cycle pulse when the last pixel of the frame is consumed

Behaviour:
- Reset (async, rst=0): state IDLE; counters 0; FIFO empty; all outputs 0.
- FSM:
  - IDLE -> SKIP on frame_start.
  - SKIP: counts in_en beats. After LAG_PIX beats -> RUN with x=0, y=0. Flags seen in SKIP are ignored.
  - RUN: each in_en beat maps to pixel (x,y); x increments and wraps at IMG_W-1 to 0 with y+1.
  - RUN -> DONE on the beat at (IMG_W-1, IMG_H-1), with a frame_done pulse on the next cycle.
  - DONE: in_en is ignored. DONE -> SKIP on frame_start.
- frame_start in any state, including mid-frame in SKIP or RUN: skip counter, x and y reset to 0; state -> SKIP; kp_count and overflow cleared. FIFO contents are kept. If frame_start coincides with in_en, the beat counts as skip beat 0.
- Qualification (RUN beat): in_flag=1, BORDER<=x<=IMG_W-1-BORDER, BORDER<=y<=IMG_H-1-BORDER, and |in_val|>=CONTRAST_TH. |in_val| is computed in 9 bits, so -128 gives 128.
- Pipeline: stage 1 registers the qualification and the coordinates; stage 2 writes the FIFO.
- FIFO is first-word-fall-through. For a qualified beat at edge t into an empty FIFO, kp_valid=1 after edge t+2.
- Pop occurs when kp_valid && kp_ready. A push while full succeeds only if a pop happens in the same cycle; otherwise the entry is dropped and overflow <= 1.
- kp_count increments on each successful push.
- kp_x/kp_y/kp_val are don't-care while kp_valid=0, and are held stable while kp_valid=1 && kp_ready=0.

Optional Feature:
KP_POLARITY_EN:
- Defined: adds output kp_pol (1 bit, 1 = maximum, i.e. in_val>=0; 0 = minimum). It is stored in the FIFO word and widens the word by 1 bit.
- Undefined: the port and the storage bit are absent. All other behaviour is identical.

Decomposition:
- Package sift_kp_pkg holds:
  - state enum (IDLE, SKIP, RUN, DONE)
  - keypoint word type {x, y, val[, pol]}
  - helper constant for word width
  - abs-value function
- One sub-module, sift_kp_fifo: parameterised FWFT synchronous FIFO with push/pop/full/empty and the same-cycle push-when-full rule.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, LAG_PIX=9, BORDER=1, CONTRAST_TH=3, FIFO_DEPTH=4, kp_ready=1 unless stated.
1. frame_start, then flag=1, val=10 on beat 28 -> kp_valid two cycles later with kp_x=3, kp_y=2, kp_val=10, kp_count=1.
2. Flags on beat 9 (0,0, val 50), beat 16 (7,0) and beat 17 (0,1) -> nothing queued; flag on beat 18 (1,1, val 50) -> queued with x=1, y=1.
3. Interior flags with val=-2, 2, 3, -128 -> only 3 and -128 queued, in that order; kp_count=2.
4. kp_ready=0 with 5 qualified interior flags -> 4 entries stored, overflow=1, kp_count=4. Raising kp_ready drains them in order, then kp_valid=0.
5. 57 beats after frame_start -> exactly one frame_done pulse after beat 56. Extra beats produce no keypoints. A new frame_start clears kp_count and overflow but keeps the FIFO.
6. Assert rst mid-RUN with 2 entries queued -> kp_valid=0 and all outputs 0 immediately; after release the block stays in IDLE until frame_start.
